// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - request capture, masking and one-hot grant hold ahead of the 8-to-3 encoder (edge mode under IRQ_EDGE_DETECT_EN, level mode otherwise)
module irq_pending_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic       ovr_clr,
    output logic [7:0] grant,
    output logic       grant_vld,
    output logic [7:0] pending,
    output logic [7:0] overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] grant_nxt;
    logic       grant_vld_nxt;
    logic [7:0] pending_nxt;
    logic [7:0] overrun_nxt;
    logic [7:0] req_q;
    logic [7:0] eligible;

    // Ascending scan so the highest set bit is the last one written.
    function automatic logic [7:0] top_onehot(input logic [7:0] v);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                res = 8'h01 << i;
            end
        end
        return res;
    endfunction

    assign eligible = pending & mask;

`ifdef IRQ_EDGE_DETECT_EN
    logic [7:0] evt;
    logic [7:0] ack_clr;
    logic [7:0] ovr_set;

    always_comb begin
        ack_clr     = ((state == GRANT) && ack) ? grant : 8'h00;
        evt         = req & ~req_q;
        ovr_set     = evt & pending & ~ack_clr;
        // A new edge on the bit being acked re-arms it rather than being lost.
        pending_nxt = (pending & ~ack_clr) | evt;
        overrun_nxt = (ovr_clr ? 8'h00 : overrun) | ovr_set;
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{ovr_clr, req_q};

    always_comb begin
        pending_nxt = req;
        overrun_nxt = 8'h00;
    end
`endif

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_vld_nxt = grant_vld;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt     = top_onehot(eligible);
                    grant_vld_nxt = 1'b1;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    grant_nxt     = 8'h00;
                    grant_vld_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                grant_nxt     = 8'h00;
                grant_vld_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= 8'h00;
            grant_vld <= 1'b0;
            pending   <= 8'h00;
            overrun   <= 8'h00;
            req_q     <= 8'h00;
        end else begin
            grant     <= grant_nxt;
            grant_vld <= grant_vld_nxt;
            pending   <= pending_nxt;
            overrun   <= overrun_nxt;
            req_q     <= req;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - randomized self-checking bench for irq_pending_ctrl against a line-indexed reference model
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       ack = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] grant;
    logic       grant_vld;
    logic [7:0] pending;
    logic [7:0] overrun;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] m_pend;
    bit [7:0] m_ovr;
    bit [7:0] m_prev;
    int       m_g;

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .ack       (ack),
        .ovr_clr   (ovr_clr),
        .grant     (grant),
        .grant_vld (grant_vld),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [7:0] exp_grant();
        bit [7:0] g;
        g = 8'h00;
        if (m_g >= 0) g[m_g] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00;
        m_ovr  = 8'h00;
        m_prev = 8'h00;
        m_g    = -1;
    endtask

    task automatic model_clock(input bit [7:0] r, input bit [7:0] m, input bit a, input bit oc);
        bit [7:0] np;
        bit [7:0] no;
        bit [7:0] clr;
        bit       rose;
        int       ng;
        clr = 8'h00;
        if (m_g >= 0 && a) clr[m_g] = 1'b1;
`ifdef IRQ_EDGE_DETECT_EN
        no = oc ? 8'h00 : m_ovr;
        for (int i = 0; i < 8; i++) begin
            rose  = r[i] && !m_prev[i];
            np[i] = rose || (m_pend[i] && !clr[i]);
            if (rose && m_pend[i] && !clr[i]) no[i] = 1'b1;
        end
`else
        np = r;
        no = 8'h00;
`endif
        ng = m_g;
        if (m_g < 0) begin
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && m[i]) ng = i;
            end
        end else if (a) begin
            ng = -1;
        end
        m_pend = np;
        m_ovr  = no;
        m_g    = ng;
        m_prev = r;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"},   grant,            exp_grant());
        check({tag, ".vld"},     {7'h0, grant_vld}, {7'h0, m_g >= 0});
        check({tag, ".pending"}, pending,          m_pend);
        check({tag, ".overrun"}, overrun,          m_ovr);
    endtask

    task automatic step(input bit [7:0] r, input bit [7:0] m, input bit a, input bit oc);
        req     = r;
        mask    = m;
        ack     = a;
        ovr_clr = oc;
        model_clock(r, m, a, oc);
        @(posedge clk);
        @(negedge clk);
        check_all("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [7:0] r;
        bit [7:0] m;
        model_reset();

        req  = 8'hFF;
        mask = 8'hFF;
        repeat (2) @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("rel_pending", pending, 8'hFF);
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("rel_grant", grant, 8'h80);
        check("rel_vld", {7'h0, grant_vld}, 8'h01);

        do_reset();
        step(8'h02, 8'hFF, 1'b0, 1'b0);
        step(8'h02, 8'hFF, 1'b0, 1'b0);
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        check("stable_grant", grant, 8'h02);
        step(8'hFF, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        check("stray_ack_vld", {7'h0, grant_vld}, 8'h00);

`ifdef IRQ_EDGE_DETECT_EN
        do_reset();
        step(8'h05, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        check("prio_first", grant, 8'h04);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        check("prio_second", grant, 8'h01);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        check("prio_drain_pend", pending, 8'h00);

        step(8'h80, 8'h7F, 1'b0, 1'b0);
        step(8'h00, 8'h7F, 1'b0, 1'b0);
        check("mask_block", grant, 8'h00);
        check("mask_pend", pending, 8'h80);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        check("mask_release", grant, 8'h80);
        step(8'h00, 8'hFF, 1'b1, 1'b0);

        step(8'h08, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        check("ovr_set", overrun, 8'h08);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b1, 1'b0);
        check("setwins_pend", pending, 8'h08);
        check("setwins_ovr", overrun, 8'h08);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        check("setwins_regrant", grant, 8'h08);
        step(8'h00, 8'hFF, 1'b1, 1'b1);
        check("ovr_clr", overrun, 8'h00);
`else
        do_reset();
        step(8'h10, 8'hFF, 1'b0, 1'b0);
        step(8'h10, 8'hFF, 1'b0, 1'b0);
        check("lvl_grant0", grant, 8'h10);
        for (int k = 0; k < 4; k++) begin
            step(8'h10, 8'hFF, 1'b1, 1'b1);
            check("lvl_gap", grant, 8'h00);
            step(8'h10, 8'hFF, 1'b0, 1'b0);
            check("lvl_regrant", grant, 8'h10);
            check("lvl_ovr", overrun, 8'h00);
        end
`endif

        do_reset();
        r = 8'h00;
        m = 8'hFF;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            r = r ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) m = 8'($urandom);
            if ($urandom_range(0, 9) == 0) m = 8'hFF;
            step(r, m, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Request-capture and grant stage that sits directly upstream of the 8-to-3 priority encoder. It latches events on 8 request lines into a pending register and applies a per-line enable mask. It presents the highest-priority eligible request to the encoder as a stable one-hot vector and holds it until the consumer acknowledges. Only one-hot grants are ever driven, which is the input form the encoder decodes with valid=1.

## Interface
Parameters: none (8 lines fixed, matching the encoder width).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request lines; synchronous to clk
- mask  input  8  per-line enable; 1 = line eligible for grant
- ack  input  1  consumer acknowledge of the current grant; single-cycle pulse
- ovr_clr  input  1  clears all overrun flags
- grant  output  8  one-hot grant to the encoder d input; 8'h00 when no grant
- grant_vld  output  1  grant holds a valid one-hot value
- pending  output  8  captured, not-yet-serviced requests, before masking
- overrun  output  8  sticky; event arrived on a line already pending

## Operation
- Priority: bit 7 is highest, bit 0 lowest. The winner is the highest set bit of (pending & mask).
- Edge capture: req_q <= req each cycle. Rising edge is defined as evt = req & ~req_q. On evt[i], pending[i] <= 1.
- States:
  - IDLE: grant = 0 and grant_vld = 0. If (pending & mask) != 0, register the one-hot winner into grant, set grant_vld, and go to GRANT.
  - GRANT: grant and grant_vld are held stable regardless of req, mask or pending changes. On ack, clear pending at the granted bit, drive grant = 0 and grant_vld = 0, and go to IDLE.
- A line is re-evaluated for grant only in IDLE. The minimum spacing between successive grants is 2 cycles (the GRANT cycle with ack, then IDLE).
- ack while in IDLE is ignored; no state change.
- Overrun: if evt[i] occurs while pending[i] = 1 and bit i is not being cleared by ack in that cycle, set overrun[i].
  - ovr_clr clears all overrun bits.
  - If ovr_clr and a new overrun event happen in the same cycle, set wins.
- Simultaneous events:
  - If evt[i] coincides with the ack clear of bit i, pending[i] stays 1 (set wins) and no overrun is flagged.
  - Events on multiple lines in one cycle are all captured.
- Masked lines still capture into pending and still flag overrun. They are never granted while masked, and become eligible as soon as unmasked in IDLE.

## Timing
- Reset values (asynchronous, on rst_n low): grant = 8'h00, grant_vld = 0, pending = 8'h00, overrun = 8'h00, req_q = 8'h00, state = IDLE.
- Reset mid-GRANT drops the grant immediately and discards all pending requests.
- The first rising edge after reset release sees req_q = 0. Any req line already high at that edge counts as an event.
- Latency: req[i] first sampled high at edge k sets pending[i] after k. grant and grant_vld are asserted after edge k+1 when the controller is in IDLE and the line is eligible.
- ack is sampled at the rising edge. grant_vld deasserts after that same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- IRQ_EDGE_DETECT_EN defined: edge-capture behaviour as described above.
- IRQ_EDGE_DETECT_EN undefined: level mode.
  - pending <= req every cycle, and ack does not clear pending.
  - After ack the controller returns to IDLE and re-grants if the line is still high and enabled.
  - overrun is tied to 8'h00 and ovr_clr is ignored.
  - Grant latency stays 2 edges from req sampled high.

## Test plan
- Reset: hold rst_n = 0 with req = 8'hFF. Required: all outputs 0. Release with req = 8'hFF, mask = 8'hFF. Required: pending = 8'hFF after 1 edge; grant = 8'h80, grant_vld = 1 after 2 edges.
- Priority and service order: pulse req = 8'h05 for 1 cycle with mask = 8'hFF, and ack each grant. Required: grant 8'h04 then 8'h01, then grant_vld = 0 with pending = 8'h00.
- Masking: req = 8'h80 pulse with mask = 8'h7F. Required: pending = 8'h80 and no grant. Set mask = 8'hFF. Required: grant = 8'h80 two edges later.
- Overrun and set-wins: pulse req[3] twice while unacked. Required: overrun = 8'h08. A second req[3] edge in the same cycle as ack of grant 8'h08 leaves pending[3] = 1, does not add overrun, and re-grants 8'h08 after IDLE. ovr_clr then gives overrun = 8'h00.
- Stability: change mask to 8'h00 and raise req = 8'hFF during GRANT of 8'h02. Required: grant stays 8'h02 until ack. A stray ack in IDLE causes no change.
- Level mode (macro undefined): hold req = 8'h10 and ack every grant. Required: grant = 8'h10 repeats every 2 cycles and overrun stays 8'h00.
